pc_unit: RTL and testbench

- Program-counter register and next-PC selector for the 8-bit-address MIPS unicycle core.
- Sits directly upstream of the PC+1 adder and feeds it PCResult. Consumes the adder's PCAdd, the control unit's branch/jump decisions and the halt decision.
- Each clock edge it selects and registers the next fetch address.
- Adds a run/halted state machine and a saturating retired-instruction counter for debug.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 41 ++++
 rtl/pc_unit.sv | 97 +++++++++
 tb/tb_pc_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC unit.
// Widths, run/halt state codes and next-PC select codes.
package pc_pkg;

    localparam int PC_ADDR_W = 8;
    localparam int PC_CNT_W  = 8;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection logic for the PC unit.
// Purely combinational: select code plus branch target.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W
) (
    input  logic              i_state,
    input  logic [ADDR_W-1:0] i_pc_add,
    input  logic              i_branch,
    input  logic [ADDR_W-1:0] i_branch_off,
    input  logic              i_jump,
    input  logic              i_stall,
    input  logic              i_halt,
    input  logic              i_resume,
    output sel_t              o_sel,
    output logic [ADDR_W-1:0] o_br_target
);

    assign o_br_target = i_pc_add + i_branch_off;

    // Halt outranks stall so a stalled halt still parks the core.
    always_comb begin
        o_sel = SEL_HOLD;
        if (i_state == ST_HALTED) begin
            if (i_resume)
                o_sel = SEL_SEQ;
        end else if (i_halt) begin
            o_sel = SEL_HOLD;
        end else if (i_stall) begin
            o_sel = SEL_HOLD;
        end else if (i_jump) begin
            o_sel = SEL_JUMP;
        end else if (i_branch) begin
            o_sel = SEL_BRANCH;
        end else begin
            o_sel = SEL_SEQ;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter register with run/halt FSM
// and a saturating retired-instruction counter.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = PC_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCAdd,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchOffset,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpAddr,
    input  logic              Stall,
    input  logic              Halt,
    input  logic              Resume,
    output logic [ADDR_W-1:0] PCResult,
    output logic              Halted,
    output logic [CNT_W-1:0]  RetiredCount
);

    logic              r_state;
    logic              w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_br_target;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_adv;
    sel_t              w_sel;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_sel (
        .i_state      (r_state),
        .i_pc_add     (PCAdd),
        .i_branch     (Branch),
        .i_branch_off (BranchOffset),
        .i_jump       (Jump),
        .i_stall      (Stall),
        .i_halt       (Halt),
        .i_resume     (Resume),
        .o_sel        (w_sel),
        .o_br_target  (w_br_target)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_HALTED) begin
            if (Resume)
                w_state_next = ST_RUN;
        end else if (Halt) begin
            w_state_next = ST_HALTED;
        end
    end

    always_comb begin
        Halted = (r_state == ST_HALTED);
    end

    always_comb begin
        w_pc_next = r_pc;
        unique case (w_sel)
            SEL_HOLD:   w_pc_next = r_pc;
            SEL_SEQ:    w_pc_next = PCAdd;
            SEL_BRANCH: w_pc_next = w_br_target;
            SEL_JUMP:   w_pc_next = JumpAddr;
            default:    w_pc_next = r_pc;
        endcase
    end

    assign w_adv = (w_sel != SEL_HOLD);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_adv && !(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign PCResult     = r_pc;
    assign RetiredCount = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a cycle model
// compared on every falling edge.
module tb_pc_unit;

    logic       Clk;
    logic       Reset;
    logic [7:0] PCAdd;
    logic       Branch;
    logic [7:0] BranchOffset;
    logic       Jump;
    logic [7:0] JumpAddr;
    logic       Stall;
    logic       Halt;
    logic       Resume;
    logic [7:0] PCResult;
    logic       Halted;
    logic [7:0] RetiredCount;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_pc;
    logic       m_halt;
    logic [7:0] m_cnt;

    pc_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCAdd        (PCAdd),
        .Branch       (Branch),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpAddr     (JumpAddr),
        .Stall        (Stall),
        .Halt         (Halt),
        .Resume       (Resume),
        .PCResult     (PCResult),
        .Halted       (Halted),
        .RetiredCount (RetiredCount)
    );

    assign PCAdd = PCResult + 8'd1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: what one instruction step does, in plain arithmetic.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_pc   <= 8'h00;
            m_halt <= 1'b0;
            m_cnt  <= 8'd0;
        end else begin
            automatic int  npc  = m_pc;
            automatic bit  nh   = m_halt;
            automatic bit  step = 0;
            if (m_halt) begin
                if (Resume) begin
                    nh = 0;
                    npc = m_pc + 1;
                    step = 1;
                end
            end else if (Halt) begin
                nh = 1;
            end else if (!Stall) begin
                step = 1;
                if (Jump)
                    npc = JumpAddr;
                else if (Branch)
                    npc = m_pc + 1 + $signed(BranchOffset);
                else
                    npc = m_pc + 1;
            end
            m_pc   <= 8'(npc % 256);
            m_halt <= nh;
            if (step && m_cnt < 255)
                m_cnt <= m_cnt + 8'd1;
        end
    end

    always @(negedge Clk) begin
        chk("model_pc", int'(PCResult), int'(m_pc));
        chk("model_halted", int'(Halted), int'(m_halt));
        chk("model_cnt", int'(RetiredCount), int'(m_cnt));
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pin(input string nm, input int pc,
                       input int h, input int c);
        chk({nm, "_pc"}, int'(PCResult), pc);
        chk({nm, "_halted"}, int'(Halted), h);
        chk({nm, "_cnt"}, int'(RetiredCount), c);
    endtask

    initial begin
        Reset = 1'b0;
        Branch = 0; BranchOffset = 0;
        Jump = 0; JumpAddr = 0;
        Stall = 0; Halt = 0; Resume = 0;
        step(); step();
        pin("reset", 8'h00, 0, 0);
        Reset = 1'b1;
        step(); step(); step();
        pin("free3", 8'h03, 0, 3);
        step(); step();
        pin("pc5", 8'h05, 0, 5);
        Branch = 1; BranchOffset = 8'hFC;
        step();
        pin("branch_neg", 8'h02, 0, 6);
        Jump = 1; JumpAddr = 8'h40;
        step();
        pin("jump_prio", 8'h40, 0, 7);
        Branch = 0; JumpAddr = 8'h10;
        step();
        Stall = 1; JumpAddr = 8'h80;
        step(); step();
        pin("stall", 8'h10, 0, 8);
        Stall = 0; Jump = 0;
        step();
        pin("unstall", 8'h11, 0, 9);
        Jump = 1; JumpAddr = 8'h20;
        step();
        Jump = 0; Halt = 1; Stall = 1;
        step();
        pin("halt", 8'h20, 1, 10);
        Halt = 0; Stall = 0; JumpAddr = 8'h80;
        for (int i = 0; i < 4; i++) begin
            Jump = i[0];
            step();
        end
        Jump = 0;
        pin("halted_hold", 8'h20, 1, 10);
        Halt = 1; Resume = 1;
        step();
        pin("resume", 8'h21, 0, 11);
        Halt = 0; Resume = 0;
        Jump = 1; JumpAddr = 8'h33;
        step();
        Jump = 0; Halt = 1;
        step();
        Halt = 0;
        step();
        pin("halt33", 8'h33, 1, 12);
        #2 Reset = 1'b0;
        #1 pin("async_rst", 8'h00, 0, 0);
        step();
        Reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) pin("at_ff", 8'hFF, 0, 255);
            if (i == 255) pin("wrap", 8'h00, 0, 255);
        end
        pin("sat", 8'h2C, 0, 255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
